// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The loader turns a byte stream into 32-bit words and writes them to instruction memory.
package imem_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words,
// writes them to instruction memory and keeps the CPU in reset until done.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = imem_pkg::DEPTH,
  parameter int ADDR_W = imem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W:0]   words_loaded,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  loader_state_t     state_q;
  loader_state_t     state_d;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_addr;
  logic [WORD_W-1:0] asm_word;
  logic              last_word;
  logic              at_last_addr;

  assign at_last_addr = (word_addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (in_valid) begin
          if (byte_cnt == 2'd3)  state_d = WRITE;
          else if (in_last)      state_d = ERROR;
        end
      end
      WRITE: begin
        if (last_word)         state_d = DONE;
        else if (at_last_addr) state_d = ERROR;
        else                   state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends on state alone, so there is no path from in_valid to in_ready.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // Byte assembly and word bookkeeping; last_word remembers in_last of the 4th byte for WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt     <= '0;
      word_addr    <= '0;
      words_loaded <= '0;
      asm_word     <= '0;
      last_word    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            byte_cnt     <= '0;
            word_addr    <= '0;
            words_loaded <= '0;
            asm_word     <= '0;
            last_word    <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            asm_word[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) last_word <= in_last;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          if (!last_word && !at_last_addr) word_addr <= word_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr = word_addr;
  assign wr_data = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are driven
// and matched against every wr_en pulse seen on the falling clock edge.
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   words_loaded;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  wr_t               expQ[$];
  int                checks = 0;
  int                errors = 0;
  logic [ADDR_W-1:0] nextAddr;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .words_loaded(words_loaded), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Every write must match the oldest queued expectation, and WRITE must not accept bytes.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checkOutput("wr_in_ready", 64'(in_ready), 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("wr_pending", 64'(expQ.size()), 64'd1);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
        checkOutput("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
  endtask

  // Drives one byte until it is accepted (bounded), optionally followed by an idle cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input bit gap);
    logic ready;
    bit   accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      ready = in_ready;
      waitCycles(1);
      if (ready) accepted = 1'b1;
    end
    if (!accepted) checkOutput("handshake_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (gap) waitCycles(1);
  endtask

  task automatic applyWord(input logic [31:0] w, input bit last, input bit gap);
    wr_t e;
    e.addr = nextAddr;
    e.data = w;
    expQ.push_back(e);
    nextAddr = nextAddr + 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], last && (k == 3), gap);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    nextAddr = '0;
    waitCycles(3);
    reset = 1'b0;

    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("rst_flags", 64'({busy, done, error}), 64'd0);
    checkOutput("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_words", 64'(words_loaded), 64'd0);

    // Single word with in_last on its 4th byte.
    pulseStart();
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_in_ready", 64'(in_ready), 64'd1);
    applyWord(32'h00100513, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_cpu_hold", 64'(cpu_hold), 64'd0);
    checkOutput("t1_words", 64'(words_loaded), 64'd1);
    checkOutput("t1_queue", 64'(expQ.size()), 64'd0);

    // Three words with in_valid toggling every other cycle.
    nextAddr = '0;
    pulseStart();
    checkOutput("t2_done_cleared", 64'(done), 64'd0);
    applyWord($urandom, 1'b0, 1'b1);
    applyWord($urandom, 1'b0, 1'b1);
    applyWord($urandom, 1'b1, 1'b1);
    checkOutput("t2_done", 64'(done), 64'd1);
    checkOutput("t2_words", 64'(words_loaded), 64'd3);
    checkOutput("t2_queue", 64'(expQ.size()), 64'd0);

    // Partial second word: in_last on its 2nd byte.
    nextAddr = '0;
    pulseStart();
    applyWord(32'hCAFEF00D, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b1, 1'b0);
    checkOutput("t3_error", 64'(error), 64'd1);
    checkOutput("t3_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("t3_words", 64'(words_loaded), 64'd1);
    checkOutput("t3_in_ready", 64'(in_ready), 64'd0);
    waitCycles(2);
    checkOutput("t3_queue", 64'(expQ.size()), 64'd0);
    pulseStart();
    checkOutput("t3_restart_err", 64'(error), 64'd0);
    checkOutput("t3_restart_busy", 64'(busy), 64'd1);

    // Reset mid-word, with a byte offered in the reset cycle.
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    waitCycles(1);
    reset    = 1'b0;
    checkOutput("t4_in_ready", 64'(in_ready), 64'd0);
    checkOutput("t4_wr_en", 64'(wr_en), 64'd0);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    checkOutput("t4_cpu_hold", 64'(cpu_hold), 64'd1);
    waitCycles(3);
    in_valid = 1'b0;
    checkOutput("t4_still_idle", 64'(busy), 64'd0);

    // Overflow: DEPTH full words and no in_last.
    nextAddr = '0;
    pulseStart();
    for (int w = 0; w < DEPTH; w++) applyWord($urandom, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t5_error", 64'(error), 64'd1);
    checkOutput("t5_in_ready", 64'(in_ready), 64'd0);
    checkOutput("t5_words", 64'(words_loaded), 64'(DEPTH));
    checkOutput("t5_queue", 64'(expQ.size()), 64'd0);

    // start held through a load, then a reload from DONE restarts at address 0.
    nextAddr = '0;
    start = 1'b1;
    waitCycles(1);
    applyWord(32'h12345678, 1'b0, 1'b0);
    applyWord(32'h9ABCDEF0, 1'b1, 1'b0);
    start = 1'b0;
    waitCycles(1);
    checkOutput("t6_done", 64'(done), 64'd1);
    checkOutput("t6_words", 64'(words_loaded), 64'd2);
    nextAddr = '0;
    pulseStart();
    checkOutput("t6_words_clear", 64'(words_loaded), 64'd0);
    applyWord(32'h0BADBEEF, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("t6_done2", 64'(done), 64'd1);
    checkOutput("t6_words2", 64'(words_loaded), 64'd1);
    checkOutput("t6_queue", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
